rsa_job_arbiter: RTL and testbench
==================================

// Module: rsa_job_arbiter
// PURPOSE
//  Shares one modular-exponentiation engine (base^expo mod N, start-as-reset, done/valid out)
//  among NUM_REQ requesters. Round-robin arbitration, operand capture, engine start sequencing,
//  completion wait with watchdog, and result return over a valid/ready response channel.
//  Sits between the requester fabric and the single engine instance; the engine is never
//  driven by anyone else.
// PARAMETERS
//  NUM_REQ   4    number of requesters (>=2)
//  ID_W      2    requester id width, clog2(NUM_REQ)
//  BASE_W    6    base operand width
//  EXPO_W    6    exponent operand width
//  N_W       6    modulus / result width
//  TIMEOUT   72   max RUN cycles before abort (>= 2^EXPO_W+2)
// PORTS
//  clk          in   1               rising-edge clock
//  rst_n        in   1               asynchronous active-low reset
//  req          in   NUM_REQ         per-requester request, held until matching gnt bit
//  req_base     in   NUM_REQ*BASE_W  packed bases, slice i = requester i
//  req_expo     in   NUM_REQ*EXPO_W  packed exponents
//  req_n        in   NUM_REQ*N_W     packed moduli
//  gnt          out  NUM_REQ         one-hot, 1-cycle pulse: operands of that requester captured
//  rsp_valid    out  1               response available
//  rsp_ready    in   1               response accepted when rsp_valid&rsp_ready
//  rsp_id       out  ID_W            requester owning the response
//  rsp_result   out  N_W             base^expo mod N (0 on error)
//  rsp_err      out  1               1 = watchdog abort
//  busy         out  1               state != IDLE
//  eng_start    out  1               engine start/reset, high = engine held in reset
//  eng_base     out  BASE_W          registered operand, stable from START until IDLE
//  eng_expo     out  EXPO_W          registered operand
//  eng_n        out  N_W             registered operand
//  eng_result   in   N_W             engine result, meaningful when eng_valid
//  eng_valid    in   1               engine done
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, gnt=0, rsp_valid=0, rsp_err=0, rsp_id=0, rsp_result=0,
//   eng_start=1, eng_base/expo/n=0, rr pointer=NUM_REQ-1 (so requester 0 wins first), timer=0.
//  FSM IDLE -> START -> RUN -> RESP -> IDLE; all outputs registered.
//  IDLE: eng_start=1. If |req: winner = first set bit searching from (ptr+1) mod NUM_REQ upward,
//   wrapping; capture winner's operands into eng_*, rsp_id<=winner, ptr<=winner, ->START.
//  START (1 cycle): gnt[winner]=1, eng_start=1 with new operands stable; timer<=0; ->RUN.
//  RUN: eng_start=0. eng_valid sampled every cycle incl. first (expo=0 completes immediately).
//   eng_valid=1: rsp_result<=eng_result, rsp_err<=0, ->RESP.
//   else timer+1; timer reaches TIMEOUT-1 without valid: rsp_result<=0, rsp_err<=1, ->RESP.
//  RESP: eng_start=1 (engine parked), rsp_valid=1, rsp_* stable until rsp_ready; on handshake
//   rsp_valid<=0, ->IDLE. No new grant in the handshake cycle; next arbitration in IDLE.
//  Requests arriving outside IDLE are held pending; req is never sampled outside IDLE.
//  Requester must drop req the cycle after its gnt; a still-high req in IDLE is a new job.
//  Operand widths pass through unchanged; no arithmetic besides timer (clog2(TIMEOUT)+1 bits).
//  Throughput: min 4 cycles/job + engine latency (expo+2 cycles for expo>0).
//  Reset mid-operation: immediate abort, no response for in-flight job, pointer reset.
// TESTING
//  1 req[0] base=5 expo=3 N=13 -> gnt[0] pulse 1 cycle after req, rsp_id=0 result=8 err=0.
//  2 req[2] base=7 expo=0 N=1 -> result=0; base=7 expo=0 N=11 -> result=1, both within 4 cycles of gnt.
//  3 req=4'b1111 held after reset -> grants in order 0,1,2,3, each gnt only after prior RESP handshake.
//  4 rsp_ready=0 for 10 cycles in RESP -> rsp_valid/id/result stable, no gnt, busy=1; then accepted.
//  5 engine model never asserts eng_valid -> rsp_err=1 result=0 exactly TIMEOUT cycles after RUN entry.
//  6 rst_n low mid-RUN -> all outputs to reset values asynchronously; next job (7^2 mod 11) -> 5.

Source files
------------

// File: rtl/rsa_job_arbiter.sv
// Round-robin front end for a single shared modular-exponentiation engine:
// arbitrates requesters, captures operands, sequences the engine and returns results.
module rsa_job_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int BASE_W  = 6,
   parameter int EXPO_W  = 6,
   parameter int N_W     = 6,
   parameter int TIMEOUT = 72
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*BASE_W-1:0]   req_base,
   input  logic [NUM_REQ*EXPO_W-1:0]   req_expo,
   input  logic [NUM_REQ*N_W-1:0]      req_n,
   output logic [NUM_REQ-1:0]          gnt,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [ID_W-1:0]             rsp_id,
   output logic [N_W-1:0]              rsp_result,
   output logic                        rsp_err,
   output logic                        busy,
   output logic                        eng_start,
   output logic [BASE_W-1:0]           eng_base,
   output logic [EXPO_W-1:0]           eng_expo,
   output logic [N_W-1:0]              eng_n,
   input  logic [N_W-1:0]              eng_result,
   input  logic                        eng_valid
);

   localparam int TMR_W = $clog2(TIMEOUT) + 1;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(NUM_REQ - 1);

   logic [1:0]          state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
   logic [N_W-1:0]      rsp_result_q, rsp_result_d;
   logic                busy_q, busy_d;
   logic                eng_start_q, eng_start_d;
   logic [BASE_W-1:0]   eng_base_q, eng_base_d;
   logic [EXPO_W-1:0]   eng_expo_q, eng_expo_d;
   logic [N_W-1:0]      eng_n_q, eng_n_d;

   logic                win_found;
   logic [ID_W-1:0]     win_idx;

   // Search starts just after the last winner, so the last winner has lowest priority.
   always_comb begin
      int idx;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (!win_found && req[idx[ID_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      timer_d      = timer_q;
      gnt_d        = '0;
      rsp_valid_d  = rsp_valid_q;
      rsp_err_d    = rsp_err_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      eng_start_d  = eng_start_q;
      eng_base_d   = eng_base_q;
      eng_expo_d   = eng_expo_q;
      eng_n_d      = eng_n_q;
      case (state_q)
         S_IDLE: begin
            eng_start_d = 1'b1;
            if (win_found) begin
               eng_base_d      = req_base[int'(win_idx)*BASE_W +: BASE_W];
               eng_expo_d      = req_expo[int'(win_idx)*EXPO_W +: EXPO_W];
               eng_n_d         = req_n[int'(win_idx)*N_W +: N_W];
               rsp_id_d        = win_idx;
               ptr_d           = win_idx;
               gnt_d[win_idx]  = 1'b1;
               state_d         = S_START;
            end
         end
         S_START: begin
            timer_d     = '0;
            eng_start_d = 1'b0;
            state_d     = S_RUN;
         end
         S_RUN: begin
            // A valid on the watchdog's last cycle still counts as a normal completion.
            if (eng_valid) begin
               rsp_result_d = eng_result;
               rsp_err_d    = 1'b0;
               rsp_valid_d  = 1'b1;
               eng_start_d  = 1'b1;
               state_d      = S_RESP;
            end else if (timer_q == TMR_LAST) begin
               rsp_result_d = '0;
               rsp_err_d    = 1'b1;
               rsp_valid_d  = 1'b1;
               eng_start_d  = 1'b1;
               state_d      = S_RESP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         ptr_q        <= PTR_INIT;
         timer_q      <= '0;
         gnt_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         busy_q       <= 1'b0;
         eng_start_q  <= 1'b1;
         eng_base_q   <= '0;
         eng_expo_q   <= '0;
         eng_n_q      <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         timer_q      <= timer_d;
         gnt_q        <= gnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         busy_q       <= busy_d;
         eng_start_q  <= eng_start_d;
         eng_base_q   <= eng_base_d;
         eng_expo_q   <= eng_expo_d;
         eng_n_q      <= eng_n_d;
      end
   end

   assign gnt        = gnt_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_err    = rsp_err_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign busy       = busy_q;
   assign eng_start  = eng_start_q;
   assign eng_base   = eng_base_q;
   assign eng_expo   = eng_expo_q;
   assign eng_n      = eng_n_q;

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Bench for rsa_job_arbiter: engine stand-in, job-level reference model,
// directed scenarios followed by randomized traffic.
module tb_rsa_job_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int BASE_W  = 6;
   localparam int EXPO_W  = 6;
   localparam int N_W     = 6;
   localparam int TIMEOUT = 72;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*BASE_W-1:0]  req_base;
   logic [NUM_REQ*EXPO_W-1:0]  req_expo;
   logic [NUM_REQ*N_W-1:0]     req_n;
   logic [NUM_REQ-1:0]         gnt;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [ID_W-1:0]            rsp_id;
   logic [N_W-1:0]             rsp_result;
   logic                       rsp_err;
   logic                       busy;
   logic                       eng_start;
   logic [BASE_W-1:0]          eng_base;
   logic [EXPO_W-1:0]          eng_expo;
   logic [N_W-1:0]             eng_n;
   logic [N_W-1:0]             eng_result;
   logic                       eng_valid;

   rsa_job_arbiter #(
      .NUM_REQ(NUM_REQ), .ID_W(ID_W), .BASE_W(BASE_W),
      .EXPO_W(EXPO_W), .N_W(N_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_base(req_base), .req_expo(req_expo),
      .req_n(req_n), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
      .eng_start(eng_start), .eng_base(eng_base), .eng_expo(eng_expo), .eng_n(eng_n),
      .eng_result(eng_result), .eng_valid(eng_valid)
   );

   always #5 clk = ~clk;

   function automatic int modexp(int b, int e, int n);
      int r;
      if (n == 0) return 0;
      r = 1 % n;
      for (int i = 0; i < e; i++) r = (r * b) % n;
      return r;
   endfunction

   // Requester operand storage
   logic [BASE_W-1:0] op_base [NUM_REQ];
   logic [EXPO_W-1:0] op_expo [NUM_REQ];
   logic [N_W-1:0]    op_n    [NUM_REQ];

   always_comb begin
      req_base = '0;
      req_expo = '0;
      req_n    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_base[i*BASE_W +: BASE_W] = op_base[i];
         req_expo[i*EXPO_W +: EXPO_W] = op_expo[i];
         req_n[i*N_W +: N_W]          = op_n[i];
      end
   end

   // Engine stand-in: held in reset by eng_start, done expo+1 cycles after release
   int   ecnt;
   logic eng_hang;

   always @(posedge clk) begin
      if (eng_start) ecnt <= 0;
      else           ecnt <= ecnt + 1;
   end

   always_comb begin
      eng_valid  = !eng_start && !eng_hang &&
                   (ecnt >= ((eng_expo == '0) ? 0 : int'(eng_expo) + 1));
      eng_result = N_W'(modexp(int'(eng_base), int'(eng_expo), int'(eng_n)));
   end

   // Inputs as seen by the DUT at the latest rising edge
   logic [NUM_REQ-1:0] req_s;
   logic               rdy_s;
   always @(posedge clk) begin
      req_s <= req;
      rdy_s <= rsp_ready;
   end

   // Reference model: one outstanding job, described by its grant and response cycles
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   m_idle;
   int   ptr;
   int   t_gnt, t_rsp;
   int   j_id, j_base, j_expo, j_n, j_res;
   bit   j_hang;
   bit   hang_mode;
   logic [NUM_REQ-1:0] exp_gnt;
   int   gnt_log[$];
   int   gnt_cyc, rsp_cyc;
   int   last_id, last_res, last_err;

   task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
      end
   endtask

   function automatic int pick(int p, logic [NUM_REQ-1:0] r);
      for (int k = 1; k <= NUM_REQ; k++)
         if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
      return -1;
   endfunction

   task automatic model_reset();
      m_idle  = 1'b1;
      ptr     = NUM_REQ - 1;
      exp_gnt = '0;
      t_gnt   = 0;
      t_rsp   = 0;
   endtask

   task automatic tick();
      bit ev;
      int w;
      @(negedge clk);
      cyc++;
      exp_gnt = '0;
      if (m_idle) begin
         if (req_s != '0) begin
            w          = pick(ptr, req_s);
            ptr        = w;
            exp_gnt[w] = 1'b1;
            j_id       = w;
            j_base     = int'(op_base[w]);
            j_expo     = int'(op_expo[w]);
            j_n        = int'(op_n[w]);
            j_hang     = hang_mode;
            eng_hang   = hang_mode;
            t_gnt      = cyc;
            t_rsp      = j_hang ? cyc + 1 + TIMEOUT
                                : cyc + 2 + ((j_expo == 0) ? 0 : j_expo + 1);
            j_res      = j_hang ? 0 : modexp(j_base, j_expo, j_n);
            m_idle     = 1'b0;
         end
      end else if (cyc - 1 >= t_rsp && rdy_s) begin
         m_idle = 1'b1;
      end
      ev = !m_idle && (cyc >= t_rsp);
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("busy", 32'(busy), 32'(!m_idle));
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("eng_start", 32'(eng_start), 32'(!(!m_idle && cyc > t_gnt && cyc < t_rsp)));
      if (ev) begin
         chk("rsp_id", 32'(rsp_id), 32'(j_id));
         chk("rsp_result", 32'(rsp_result), 32'(j_res));
         chk("rsp_err", 32'(rsp_err), 32'(j_hang));
      end
      if (!m_idle) begin
         chk("eng_base", 32'(eng_base), 32'(j_base));
         chk("eng_expo", 32'(eng_expo), 32'(j_expo));
         chk("eng_n", 32'(eng_n), 32'(j_n));
      end
      if (gnt != '0) begin
         gnt_cyc = cyc;
         for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gnt_log.push_back(i);
      end
      if (rsp_valid) begin
         last_id  = int'(rsp_id);
         last_res = int'(rsp_result);
         last_err = int'(rsp_err);
      end
      req = req & ~exp_gnt;
   endtask

   task automatic submit(int i, int b, int e, int n);
      op_base[i] = BASE_W'(b);
      op_expo[i] = EXPO_W'(e);
      op_n[i]    = N_W'(n);
      req[i]     = 1'b1;
   endtask

   task automatic wait_rsp(int limit);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < limit && !seen; k++) begin
         tick();
         if (rsp_valid) begin
            seen    = 1'b1;
            rsp_cyc = cyc;
         end
      end
      if (!seen) chk("wait_rsp_timeout", 32'(0), 32'(1));
   endtask

   task automatic check_reset_vals(string tag);
      chk({tag, "_gnt"}, 32'(gnt), 32'(0));
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(0));
      chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(0));
      chk({tag, "_rsp_result"}, 32'(rsp_result), 32'(0));
      chk({tag, "_busy"}, 32'(busy), 32'(0));
      chk({tag, "_eng_start"}, 32'(eng_start), 32'(1));
      chk({tag, "_eng_base"}, 32'(eng_base), 32'(0));
      chk({tag, "_eng_expo"}, 32'(eng_expo), 32'(0));
      chk({tag, "_eng_n"}, 32'(eng_n), 32'(0));
   endtask

   // Asynchronous reset asserted between edges, released on a falling edge
   task automatic do_reset(string tag);
      #2 rst_n = 1'b0;
      #1 check_reset_vals(tag);
      @(negedge clk);
      rst_n = 1'b1;
      eng_hang = 1'b0;
      model_reset();
   endtask

   initial begin
      #800000;
      $display("FAIL global_watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      bit drained;
      req       = '0;
      rsp_ready = 1'b1;
      hang_mode = 1'b0;
      eng_hang  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         op_base[i] = '0;
         op_expo[i] = '0;
         op_n[i]    = N_W'(1);
      end
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("por");
      rst_n = 1'b1;

      // 5^3 mod 13, grant one cycle after the request
      submit(0, 5, 3, 13);
      tick();
      chk("t1_gnt", 32'(gnt), 32'(4'b0001));
      wait_rsp(200);
      chk("t1_id", 32'(last_id), 32'(0));
      chk("t1_result", 32'(last_res), 32'(8));
      chk("t1_err", 32'(last_err), 32'(0));

      // Zero exponent: 7^0 mod 1 and 7^0 mod 11
      submit(2, 7, 0, 1);
      wait_rsp(200);
      chk("t2a_result", 32'(last_res), 32'(0));
      chk("t2a_latency", 32'(rsp_cyc - gnt_cyc <= 4), 32'(1));
      submit(2, 7, 0, 11);
      wait_rsp(200);
      chk("t2b_result", 32'(last_res), 32'(1));
      chk("t2b_latency", 32'(rsp_cyc - gnt_cyc <= 4), 32'(1));
      tick();

      // All four requesting after reset: grants 0,1,2,3
      do_reset("rst2");
      gnt_log.delete();
      for (int i = 0; i < NUM_REQ; i++) submit(i, i + 2, i + 1, 29);
      for (int k = 0; k < 400 && !(gnt_log.size() == NUM_REQ && m_idle); k++) tick();
      chk("t3_ngrants", 32'(gnt_log.size()), 32'(NUM_REQ));
      for (int i = 0; i < NUM_REQ && i < gnt_log.size(); i++)
         chk("t3_order", 32'(gnt_log[i]), 32'(i));

      // Back-pressure: 3^5 mod 17 held for 10 cycles
      rsp_ready = 1'b0;
      submit(1, 3, 5, 17);
      wait_rsp(200);
      repeat (10) tick();
      chk("t4_valid", 32'(rsp_valid), 32'(1));
      chk("t4_id", 32'(rsp_id), 32'(1));
      chk("t4_result", 32'(rsp_result), 32'(5));
      chk("t4_busy", 32'(busy), 32'(1));
      rsp_ready = 1'b1;
      tick();
      tick();
      chk("t4_idle_after", 32'(busy), 32'(0));

      // Watchdog abort
      hang_mode = 1'b1;
      submit(3, 2, 10, 50);
      wait_rsp(300);
      hang_mode = 1'b0;
      chk("t5_err", 32'(last_err), 32'(1));
      chk("t5_result", 32'(last_res), 32'(0));
      chk("t5_cycles", 32'(rsp_cyc - (gnt_cyc + 1)), 32'(TIMEOUT));
      tick();

      // Reset in the middle of RUN, then 7^2 mod 11
      submit(0, 3, 40, 61);
      for (int k = 0; k < 20 && gnt == '0; k++) tick();
      repeat (5) tick();
      do_reset("rst_mid");
      submit(1, 7, 2, 11);
      wait_rsp(200);
      chk("t6_id", 32'(last_id), 32'(1));
      chk("t6_result", 32'(last_res), 32'(5));
      chk("t6_err", 32'(last_err), 32'(0));
      tick();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         tick();
         rsp_ready = ($urandom_range(0, 3) != 0);
         hang_mode = ($urandom_range(0, 15) == 0);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req[i] && $urandom_range(0, 5) == 0) begin
               op_base[i] = BASE_W'($urandom_range(0, 63));
               op_expo[i] = ($urandom_range(0, 3) == 0) ? EXPO_W'($urandom_range(0, 63))
                                                        : EXPO_W'($urandom_range(0, 8));
               op_n[i]    = N_W'($urandom_range(1, 63));
               req[i]     = 1'b1;
            end
         end
      end

      // Drain outstanding work
      hang_mode = 1'b0;
      rsp_ready = 1'b1;
      drained   = 1'b0;
      for (int k = 0; k < 2000 && !drained; k++) begin
         tick();
         if (m_idle && req == '0 && req_s == '0) drained = 1'b1;
      end
      chk("drain_complete", 32'(drained), 32'(1));
      chk("drain_busy", 32'(busy), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
